// File: rtl/frame_filler_if.sv
// Frame-fill request handshake plus the DRAM address/write-data FIFO push bus.
// The responder connects through the slave modport. The requester and FIFO side connects through the master modport.
interface frame_filler_if;
    logic         FF_valid;
    logic [23:0]  FF_color;
    logic [31:0]  FF_frame;
    logic         FF_ready;
    logic         ff_done;
    logic         af_full;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         wdf_full;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    modport slave (
        input  FF_valid, FF_color, FF_frame, af_full, wdf_full,
        output FF_ready, ff_done, af_wr_en, af_cmd_din, af_addr_din,
               wdf_wr_en, wdf_din, wdf_mask_din
    );

    modport master (
        output FF_valid, FF_color, FF_frame, af_full, wdf_full,
        input  FF_ready, ff_done, af_wr_en, af_cmd_din, af_addr_din,
               wdf_wr_en, wdf_din, wdf_mask_din
    );
endinterface

// File: rtl/frame_filler.sv
// Paints a whole frame with one colour by issuing 2-beat 256-bit write bursts
// into the DRAM controller's address and write-data FIFOs.
//
// state | meaning
// IDLE  | ready for a fill request
// WR1   | push burst address together with the first data beat
// WR2   | push second data beat, then advance or finish
module frame_filler #(
    parameter int WIDTH       = 800,
    parameter int HEIGHT      = 600,
    parameter int STRIDE_LOG2 = 12
) (
    input  logic           clk,
    input  logic           rst,
    frame_filler_if.slave  ffif
);
    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

    localparam logic [9:0] X_LAST    = 10'(WIDTH - 8);
    localparam logic [9:0] Y_LAST    = 10'(HEIGHT - 1);
    localparam int         ROW_SHIFT = STRIDE_LOG2 - 5;

    state_t      state_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [23:0] colour_q;
    logic [22:0] frame_q;

    logic        last_burst;
    logic        wr1_go;
    logic        wr2_go;
    logic [22:0] blk_addr;
    logic [31:0] pixel;

    assign last_burst = (x_q == X_LAST) && (y_q == Y_LAST);
    assign wr1_go     = (state_q == WR1) && !ffif.af_full && !ffif.wdf_full;
    assign wr2_go     = (state_q == WR2) && !ffif.wdf_full;

    // Frame base, row offset and x offset are all 32-byte aligned, so the sum is
    // formed directly in burst units. It wraps the same way as the 28-bit byte sum.
    assign blk_addr = frame_q + (23'(y_q) << ROW_SHIFT) + 23'(x_q[9:3]);
    assign pixel    = {8'd0, colour_q};

    assign ffif.FF_ready     = (state_q == IDLE);
    assign ffif.ff_done      = wr2_go && last_burst;
    assign ffif.af_wr_en     = wr1_go;
    assign ffif.af_cmd_din   = 3'b000;
    assign ffif.af_addr_din  = {6'd0, blk_addr, 2'd0};
    assign ffif.wdf_wr_en    = wr1_go || wr2_go;
    assign ffif.wdf_din      = {4{pixel}};
    assign ffif.wdf_mask_din = 16'h0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            frame_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ffif.FF_valid) begin
                        colour_q <= ffif.FF_color;
                        frame_q  <= ffif.FF_frame[27:5];
                        x_q      <= '0;
                        y_q      <= '0;
                        state_q  <= WR1;
                    end
                end
                WR1: begin
                    if (wr1_go) begin
                        state_q <= WR2;
                    end
                end
                WR2: begin
                    if (wr2_go) begin
                        if (last_burst) begin
                            state_q <= IDLE;
                        end else begin
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + 10'd1;
                            end else begin
                                x_q <= x_q + 10'd8;
                            end
                            state_q <= WR1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler with a 16x2 frame. A negedge monitor logs pushes and ordering.
// A linear stimulus sequence checks them against hand-computed values.
module tb_frame_filler;
    logic clk;
    logic rst;
    frame_filler_if ffif();

    frame_filler #(.WIDTH(16), .HEIGHT(2), .STRIDE_LOG2(12)) dut (
        .clk  (clk),
        .rst  (rst),
        .ffif (ffif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [23:0] exp_color = 24'h0;

    int af_cnt = 0, wdf_cnt = 0, done_cnt = 0, done_cyc = 0;
    int order_err = 0, data_err = 0, pending = 0;
    logic [30:0] af_addrs[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            pending <= 0;
        end else begin
            if (ffif.af_wr_en) begin
                af_cnt <= af_cnt + 1;
                af_addrs.push_back(ffif.af_addr_din);
                if (pending != 0 || !ffif.wdf_wr_en) order_err <= order_err + 1;
                if (ffif.af_cmd_din !== 3'b000) data_err <= data_err + 1;
                pending <= 1;
            end else if (ffif.wdf_wr_en) begin
                if (pending == 0) order_err <= order_err + 1;
                else pending <= pending - 1;
            end
            if (ffif.wdf_wr_en) begin
                wdf_cnt <= wdf_cnt + 1;
                if (ffif.wdf_din !== {4{8'h00, exp_color}} || ffif.wdf_mask_din !== 16'h0)
                    data_err <= data_err + 1;
            end
            if (ffif.ff_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int start_cyc;
    task automatic start_fill(input logic [23:0] color, input logic [31:0] frame);
        @(posedge clk); #1;
        ffif.FF_valid = 1'b1;
        ffif.FF_color = color;
        ffif.FF_frame = frame;
        exp_color = color;
        start_cyc = cyc;
        @(posedge clk); #1;
        ffif.FF_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_timeout", 128'(done_cnt >= target), 128'd1);
    endtask

    int b_af, b_wdf, b_done, b_ord, b_dat;
    task automatic snap();
        b_af = af_cnt; b_wdf = wdf_cnt; b_done = done_cnt; b_ord = order_err; b_dat = data_err;
    endtask

    task automatic check_fill(input string tag, input logic [30:0] base, input int done_lat);
        check({tag, "_af_cnt"}, 128'(af_cnt - b_af), 128'd4);
        check({tag, "_wdf_cnt"}, 128'(wdf_cnt - b_wdf), 128'd8);
        check({tag, "_done_cnt"}, 128'(done_cnt - b_done), 128'd1);
        check({tag, "_done_cyc"}, 128'(done_cyc - start_cyc), 128'(done_lat));
        check({tag, "_addr0"}, 128'(af_addrs[b_af]),     128'(base));
        check({tag, "_addr1"}, 128'(af_addrs[b_af + 1]), 128'(base + 31'h004));
        check({tag, "_addr2"}, 128'(af_addrs[b_af + 2]), 128'(base + 31'h200));
        check({tag, "_addr3"}, 128'(af_addrs[b_af + 3]), 128'(base + 31'h204));
        check({tag, "_order"}, 128'(order_err - b_ord), 128'd0);
        check({tag, "_data"}, 128'(data_err - b_dat), 128'd0);
        check({tag, "_ready_after"}, 128'(ffif.FF_ready), 128'd1);
    endtask

    initial begin
        rst = 1'b1;
        ffif.FF_valid = 1'b0;
        ffif.FF_color = 24'h0;
        ffif.FF_frame = 32'h0;
        ffif.af_full  = 1'b0;
        ffif.wdf_full = 1'b0;
        #12;
        check("rst_ready", 128'(ffif.FF_ready), 128'd1);
        check("rst_done", 128'(ffif.ff_done), 128'd0);
        check("rst_af_wr", 128'(ffif.af_wr_en), 128'd0);
        check("rst_wdf_wr", 128'(ffif.wdf_wr_en), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic fill: base 0x10400000 -> burst address 0x80000, rows 4096 B apart
        snap();
        start_fill(24'h123456, 32'h1040_0000);
        check("basic_busy", 128'(ffif.FF_ready), 128'd0);
        wait_done(b_done + 1);
        check_fill("basic", 31'h80000, 8);

        // back-to-back: request in the cycle after ff_done
        snap();
        ffif.FF_valid = 1'b1;
        ffif.FF_color = 24'hABCDEF;
        ffif.FF_frame = 32'h0000_101F;
        exp_color = 24'hABCDEF;
        start_cyc = cyc;
        @(posedge clk); #1;
        ffif.FF_valid = 1'b0;
        check("b2b_busy", 128'(ffif.FF_ready), 128'd0);
        wait_done(b_done + 1);
        check_fill("b2b", 31'h00200, 8);

        // address FIFO full for the first five cycles of the fill
        snap();
        ffif.af_full = 1'b1;
        start_fill(24'h123456, 32'h1040_0000);
        repeat (4) begin @(posedge clk); #1; end
        check("afhold_no_af", 128'(af_cnt - b_af), 128'd0);
        check("afhold_no_wdf", 128'(wdf_cnt - b_wdf), 128'd0);
        ffif.af_full = 1'b0;
        wait_done(b_done + 1);
        check_fill("afhold", 31'h80000, 12);

        // data FIFO full during the second beat of burst 1, plus a request while busy
        snap();
        start_fill(24'h123456, 32'h1040_0000);
        @(posedge clk); #1;
        ffif.wdf_full = 1'b1;
        ffif.FF_valid = 1'b1;
        ffif.FF_color = 24'hFFFFFF;
        ffif.FF_frame = 32'h0000_0000;
        @(posedge clk); #1;
        ffif.FF_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("wdfhold_af", 128'(af_cnt - b_af), 128'd1);
        check("wdfhold_wdf", 128'(wdf_cnt - b_wdf), 128'd1);
        ffif.wdf_full = 1'b0;
        wait_done(b_done + 1);
        check_fill("wdfhold", 31'h80000, 11);

        // asynchronous reset between edges during burst 2
        start_fill(24'h123456, 32'h1040_0000);
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("prerst_af_wr", 128'(ffif.af_wr_en), 128'd1);
        rst = 1'b1;
        #1;
        check("midrst_ready", 128'(ffif.FF_ready), 128'd1);
        check("midrst_af_wr", 128'(ffif.af_wr_en), 128'd0);
        check("midrst_wdf_wr", 128'(ffif.wdf_wr_en), 128'd0);
        check("midrst_done", 128'(ffif.ff_done), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        snap();
        start_fill(24'h0F0F0F, 32'h1040_0000);
        wait_done(b_done + 1);
        check_fill("postrst", 31'h80000, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
